// File: rtl/sha256_miner_ctrl.sv
// Nonce-search controller for a SHA-256 engine: streams header+nonce messages, checks leading zeros.
// Optional watchdog on the engine RUN phase is enabled by defining SHA256_MINER_CTRL_TIMEOUT_EN.
module sha256_miner_ctrl (
   input  logic         clk,
   input  logic         rstn,
   input  logic         hdr_wr_en,
   input  logic [4:0]   hdr_wr_addr,
   input  logic [31:0]  hdr_wr_dat,
   input  logic [31:0]  nonce_start,
   input  logic [31:0]  nonce_end,
   input  logic [7:0]   target_zeros,
   input  logic         go_i,
   input  logic         abort_i,
   output logic         eng_rstn_o,
   input  logic         eng_ready_i,
   output logic         eng_start_o,
   output logic         eng_dbl_hash_o,
   input  logic         eng_valid_i,
   input  logic [255:0] eng_hash_i,
   output logic         fifo_wr_en_o,
   output logic [31:0]  fifo_wr_dat_o,
   input  logic         fifo_full_i,
   output logic         busy_o,
   output logic         done_o,
   output logic         found_o,
   output logic         error_o,
   output logic [31:0]  nonce_o,
   output logic [255:0] hash_o
);

   typedef enum logic [2:0] {
      IDLE, ENG_RST, WAIT_RDY, FILL, RUN, CHECK, DONE
   } state_t;

   state_t         state_q, state_d;
   logic [31:0]    nonce_q, nonce_d;
   logic [4:0]     wordIdx_q, wordIdx_d;
   logic           rstCnt_q, rstCnt_d;
   logic [255:0]   hash_q, hash_d;
   logic [31:0]    nonceOut_q, nonceOut_d;
   logic [255:0]   hashOut_q, hashOut_d;
   logic           done_q, done_d;
   logic           found_q, found_d;
   logic           error_q, error_d;
`ifdef SHA256_MINER_CTRL_TIMEOUT_EN
   logic [9:0]     wdog_q, wdog_d;
`endif

   logic           idleLike;
   logic           busy;
   logic           abortHit;
   logic [8:0]     leadZeros;
   logic           hit;
   logic [31:0]    fifoDat;
   logic [31:0]    hdrRam [0:18];

   assign idleLike = (state_q == IDLE) || (state_q == DONE);
   assign busy     = !idleLike;
   assign abortHit = abort_i && busy;

   // Header storage is deliberately left out of reset so a reset does not force a reload.
   always_ff @(posedge clk) begin
      if (hdr_wr_en && (hdr_wr_addr <= 5'd18) && idleLike) begin
         hdrRam[hdr_wr_addr] <= hdr_wr_dat;
      end
   end

   always_comb begin
      fifoDat = 32'h0000_0000;
      if (wordIdx_q <= 5'd18) begin
         fifoDat = hdrRam[wordIdx_q];
      end else if (wordIdx_q == 5'd19) begin
         fifoDat = nonce_q;
      end else if (wordIdx_q == 5'd20) begin
         fifoDat = 32'h8000_0000;
      end else if (wordIdx_q == 5'd31) begin
         fifoDat = 32'h0000_0280;
      end
   end

   // The last set bit scanned from the LSB up is the most significant one.
   always_comb begin
      leadZeros = 9'd256;
      for (int i = 0; i < 256; i++) begin
         if (hash_q[i]) begin
            leadZeros = 9'(255 - i);
         end
      end
   end

   assign hit = leadZeros >= {1'b0, target_zeros};

   assign busy_o         = busy;
   assign eng_dbl_hash_o = busy;
   assign eng_rstn_o     = rstn && (state_q != ENG_RST) && !abortHit;
   assign fifo_wr_en_o   = (state_q == FILL) && !fifo_full_i && !abortHit;
   assign eng_start_o    = (state_q == RUN) && !eng_valid_i && !abortHit;
   assign fifo_wr_dat_o  = fifoDat;
   assign done_o         = done_q;
   assign found_o        = found_q;
   assign error_o        = error_q;
   assign nonce_o        = nonceOut_q;
   assign hash_o         = hashOut_q;

   always_comb begin
      state_d    = state_q;
      nonce_d    = nonce_q;
      wordIdx_d  = wordIdx_q;
      rstCnt_d   = rstCnt_q;
      hash_d     = hash_q;
      nonceOut_d = nonceOut_q;
      hashOut_d  = hashOut_q;
      done_d     = done_q;
      found_d    = found_q;
      error_d    = error_q;
`ifdef SHA256_MINER_CTRL_TIMEOUT_EN
      wdog_d     = wdog_q;
`endif

      case (state_q)
         IDLE, DONE: begin
            if (go_i) begin
               nonce_d   = nonce_start;
               done_d    = 1'b0;
               found_d   = 1'b0;
               error_d   = 1'b0;
               rstCnt_d  = 1'b0;
               wordIdx_d = 5'd0;
               state_d   = ENG_RST;
            end
         end
         ENG_RST: begin
            if (rstCnt_q) begin
               rstCnt_d = 1'b0;
               state_d  = WAIT_RDY;
            end else begin
               rstCnt_d = 1'b1;
            end
         end
         WAIT_RDY: begin
            wordIdx_d = 5'd0;
            if (eng_ready_i) begin
               state_d = FILL;
            end
         end
         FILL: begin
            if (!fifo_full_i) begin
               if (wordIdx_q == 5'd31) begin
                  wordIdx_d = 5'd0;
                  state_d   = RUN;
`ifdef SHA256_MINER_CTRL_TIMEOUT_EN
                  wdog_d    = 10'd0;
`endif
               end else begin
                  wordIdx_d = wordIdx_q + 5'd1;
               end
            end
         end
         RUN: begin
            if (eng_valid_i) begin
               hash_d  = eng_hash_i;
               state_d = CHECK;
`ifdef SHA256_MINER_CTRL_TIMEOUT_EN
            end else if (wdog_q == 10'd1022) begin
               error_d = 1'b1;
               done_d  = 1'b1;
               found_d = 1'b0;
               state_d = DONE;
            end else begin
               wdog_d = wdog_q + 10'd1;
`endif
            end
         end
         CHECK: begin
            if (hit || (nonce_q == nonce_end)) begin
               nonceOut_d = nonce_q;
               hashOut_d  = hash_q;
               found_d    = hit;
               done_d     = 1'b1;
               state_d    = DONE;
            end else begin
               nonce_d  = nonce_q + 32'd1;
               rstCnt_d = 1'b0;
               state_d  = ENG_RST;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Abort wins over whatever the busy state was about to do.
      if (abortHit) begin
         state_d   = DONE;
         done_d    = 1'b1;
         found_d   = 1'b0;
         wordIdx_d = 5'd0;
         rstCnt_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= IDLE;
         nonce_q    <= 32'd0;
         wordIdx_q  <= 5'd0;
         rstCnt_q   <= 1'b0;
         hash_q     <= 256'd0;
         nonceOut_q <= 32'd0;
         hashOut_q  <= 256'd0;
         done_q     <= 1'b0;
         found_q    <= 1'b0;
         error_q    <= 1'b0;
`ifdef SHA256_MINER_CTRL_TIMEOUT_EN
         wdog_q     <= 10'd0;
`endif
      end else begin
         state_q    <= state_d;
         nonce_q    <= nonce_d;
         wordIdx_q  <= wordIdx_d;
         rstCnt_q   <= rstCnt_d;
         hash_q     <= hash_d;
         nonceOut_q <= nonceOut_d;
         hashOut_q  <= hashOut_d;
         done_q     <= done_d;
         found_q    <= found_d;
         error_q    <= error_d;
`ifdef SHA256_MINER_CTRL_TIMEOUT_EN
         wdog_q     <= wdog_d;
`endif
      end
   end

endmodule
